// File: rtl/fetch_stage.sv
// fetch_stage: PC generator and IF/ID pipeline register feeding decode from instructionMem.
// Optional feature IF_ALIGN_CHECK_EN adds misalign_err and halts fetch on misaligned redirect targets.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 512,
   parameter logic [31:0] PC_STEP    = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc_out,
   input  logic [31:0] imem_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        if_id_valid,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic        fetch_done
`ifdef IF_ALIGN_CHECK_EN
   ,
   output logic        misalign_err
`endif
);

   localparam logic [0:0]  ST_RUN    = 1'b0;
   localparam logic [0:0]  ST_DONE   = 1'b1;
   localparam logic [32:0] MEM_LIMIT = 33'(IMEM_BYTES);

   logic [0:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d, pc_seq;
   logic        valid_d;
   logic [31:0] inst_d, ipc_d, ipc4_d;
   logic        advance;
   logic        redirect_bad;

   // Evaluated in 33 bits so addresses near 2^32 never wrap back into range.
   function automatic logic past_end(input logic [31:0] addr);
      return ({1'b0, addr} + 33'd3) >= MEM_LIMIT;
   endfunction

   assign advance = !if_id_valid || id_ready;
   assign pc_seq  = pc_q + PC_STEP;
   assign pc_out  = pc_q;
   assign fetch_done = (state_q == ST_DONE);

`ifdef IF_ALIGN_CHECK_EN
   assign redirect_bad = (redirect_pc[1:0] != 2'b00);
`else
   assign redirect_bad = 1'b0;
`endif

   // Redirect beats everything, including a stalled decode; otherwise fetch only when the IF/ID slot frees.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = if_id_valid;
      inst_d  = if_id_inst;
      ipc_d   = if_id_pc;
      ipc4_d  = if_id_pc4;
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         valid_d = 1'b0;
         state_d = (redirect_bad || past_end(redirect_pc)) ? ST_DONE : ST_RUN;
      end else if (advance) begin
         if (state_q == ST_RUN) begin
            valid_d = 1'b1;
            inst_d  = imem_inst;
            ipc_d   = pc_q;
            ipc4_d  = pc_seq;
            pc_d    = pc_seq;
            if (past_end(pc_seq)) begin
               state_d = ST_DONE;
            end
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         pc_q        <= RESET_PC;
         if_id_valid <= 1'b0;
         if_id_inst  <= 32'h0;
         if_id_pc    <= 32'h0;
         if_id_pc4   <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         if_id_valid <= valid_d;
         if_id_inst  <= inst_d;
         if_id_pc    <= ipc_d;
         if_id_pc4   <= ipc4_d;
      end
   end

`ifdef IF_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misalign_err <= 1'b0;
      end else if (redirect_valid && redirect_bad) begin
         misalign_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus random ready/redirect traffic against a stream-level model.
// Builds with or without IF_ALIGN_CHECK_EN.
module tb_fetch_stage;

   localparam int unsigned MEM_BYTES = 32;
   localparam logic [31:0] PROG [8] = '{32'h24010001, 32'h24020005, 32'h24030002, 32'h24040001,
                                        32'h00642018, 32'h2442FFFF, 32'h24630001, 32'h20410000};

   logic        clk;
   logic        rst;
   logic [31:0] pc_out;
   logic [31:0] imem_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        if_id_valid;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic        fetch_done;
`ifdef IF_ALIGN_CHECK_EN
   logic        misalign_err;
`endif

   int checks;
   int failures;

   // Reference model: address the DUT should present next, and the word it should be holding.
   logic        m_valid;
   logic [31:0] m_pc;
   logic [31:0] m_ipc;
   logic        m_err;
   logic        m_forced;

   fetch_stage #(
      .RESET_PC   (32'h0),
      .IMEM_BYTES (MEM_BYTES),
      .PC_STEP    (32'd4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_out         (pc_out),
      .imem_inst      (imem_inst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_id_valid    (if_id_valid),
      .if_id_inst     (if_id_inst),
      .if_id_pc       (if_id_pc),
      .if_id_pc4      (if_id_pc4),
      .fetch_done     (fetch_done)
`ifdef IF_ALIGN_CHECK_EN
      ,
      .misalign_err   (misalign_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Big-endian byte view of the program image; anything past the last full word reads as zero.
   function automatic logic [31:0] memword(input logic [31:0] a);
      logic [63:0] pair;
      int          idx;
      if (a > MEM_BYTES - 4) return 32'h0;
      idx  = int'(a >> 2);
      pair = {PROG[idx], (idx == 7) ? 32'h0 : PROG[idx + 1]};
      pair = pair << (8 * int'(a[1:0]));
      return pair[63:32];
   endfunction

   function automatic logic in_range(input logic [31:0] a);
      return a <= MEM_BYTES - 4;
   endfunction

   assign imem_inst = memword(pc_out);

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      m_valid  = 1'b0;
      m_pc     = 32'h0;
      m_ipc    = 32'h0;
      m_err    = 1'b0;
      m_forced = 1'b0;
   endtask

   task automatic checkModel();
      checkOutput("pc_out", pc_out, m_pc);
      checkOutput("valid", {31'h0, if_id_valid}, {31'h0, m_valid});
      checkOutput("done", {31'h0, fetch_done}, {31'h0, (m_forced || !in_range(m_pc))});
      if (m_valid) begin
         checkOutput("inst", if_id_inst, memword(m_ipc));
         checkOutput("ipc", if_id_pc, m_ipc);
         checkOutput("ipc4", if_id_pc4, m_ipc + 32'd4);
      end
`ifdef IF_ALIGN_CHECK_EN
      checkOutput("misalign", {31'h0, misalign_err}, {31'h0, m_err});
`endif
   endtask

   // Drive one cycle of inputs, advance the model, then check just after the rising edge.
   task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      id_ready       = rdy;
      if (rv) begin
         m_valid = 1'b0;
         m_pc    = rpc;
`ifdef IF_ALIGN_CHECK_EN
         if (rpc[1:0] != 2'b00) begin
            m_err    = 1'b1;
            m_forced = 1'b1;
         end else begin
            m_forced = 1'b0;
         end
`endif
      end else if (!m_valid || rdy) begin
         if (!m_forced && in_range(m_pc)) begin
            m_valid = 1'b1;
            m_ipc   = m_pc;
            m_pc    = m_pc + 32'd4;
         end else begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      checkModel();
   endtask

   initial begin
      logic [31:0] rpc;
      checks         = 0;
      failures       = 0;
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      id_ready       = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      checkOutput("rst_valid", {31'h0, if_id_valid}, 32'h0);
      checkOutput("rst_pc_out", pc_out, 32'h0);
      checkOutput("rst_done", {31'h0, fetch_done}, 32'h0);
      checkOutput("rst_inst", if_id_inst, 32'h0);
      checkOutput("rst_ipc", if_id_pc, 32'h0);
      checkOutput("rst_ipc4", if_id_pc4, 32'h0);

      // Stream the whole image, then run off the end of memory.
      rst = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b1);
         if (k == 1) checkOutput("t1_first", if_id_inst, 32'h24010001);
      end
      checkOutput("t1_last_inst", if_id_inst, 32'h20410000);
      checkOutput("t1_last_pc", if_id_pc, 32'd28);
      checkOutput("t1_last_pc4", if_id_pc4, 32'd32);
      checkOutput("t5_done_hold", {31'h0, fetch_done}, 32'h1);
      repeat (3) applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("t5_no_valid", {31'h0, if_id_valid}, 32'h0);
      applyStimulus(1'b1, 32'h0, 1'b1);
      checkOutput("t5_redir_done", {31'h0, fetch_done}, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("t5_restart", if_id_inst, 32'h24010001);

      // Stall while holding the word at 8.
      repeat (2) applyStimulus(1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b0);
         checkOutput("t2_stall_inst", if_id_inst, 32'h24030002);
         checkOutput("t2_stall_pcout", pc_out, 32'd12);
      end
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("t2_next", if_id_inst, 32'h24040001);
      checkOutput("t2_next_pc", if_id_pc, 32'd12);

      // Redirect from 8 to 16, then redirect during a stall.
      applyStimulus(1'b1, 32'd8, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 32'd16, 1'b1);
      checkOutput("t3_bubble", {31'h0, if_id_valid}, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("t3_target", if_id_inst, 32'h00642018);
      applyStimulus(1'b1, 32'd4, 1'b0);
      checkOutput("t4_bubble", {31'h0, if_id_valid}, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("t4_target", if_id_inst, 32'h24020005);

      // Random ready/redirect traffic, including past-end and misaligned targets.
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 9))
            8:       rpc = ($urandom_range(0, 1) == 0) ? 32'd32 : 32'd36;
            9:       rpc = 32'($urandom_range(1, 27));
            default: rpc = 32'($urandom_range(0, 7) * 4);
         endcase
         applyStimulus(($urandom_range(0, 9) == 0), rpc, ($urandom_range(0, 9) < 7));
      end

      // Asynchronous reset between edges while holding the word at 20.
      applyStimulus(1'b1, 32'd20, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("t6_valid", {31'h0, if_id_valid}, 32'h0);
      checkOutput("t6_pc_out", pc_out, 32'h0);
      checkOutput("t6_done", {31'h0, fetch_done}, 32'h0);
      modelReset();
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("t6_restart", if_id_inst, 32'h24010001);

      // Misaligned redirect target.
      applyStimulus(1'b1, 32'd6, 1'b1);
`ifdef IF_ALIGN_CHECK_EN
      checkOutput("al_err", {31'h0, misalign_err}, 32'h1);
      checkOutput("al_done", {31'h0, fetch_done}, 32'h1);
      repeat (2) applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("al_no_valid", {31'h0, if_id_valid}, 32'h0);
`else
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("mis_word", if_id_inst, 32'h00052403);
      checkOutput("mis_pc", if_id_pc, 32'd6);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
